tt_um_fir: RTL and testbench

TT_UM_FIR -- requirements
Module: tt_um_fir

---
 rtl/fir_pkg.sv | 44 ++++
 rtl/fir_mac.sv | 19 +
 rtl/tt_um_fir.sv | 92 +++++++++
 tb/tb_tt_um_fir.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the 4-tap FIR (tt_um_fir).
package fir_pkg;

  localparam int NUM_TAPS   = 4;
  localparam int DATA_W     = 8;
  localparam int COEF_W     = 8;
  localparam int ACC_W      = 18;
  localparam int OUT_SHIFT  = 8;
  localparam int OUT_W      = 8;
  localparam int OUT_MAX    = (1 << OUT_W) - 1;
  localparam int TAP_ADDR_W = 2;

  localparam logic [COEF_W-1:0] COEF_RESET = COEF_W'(64);

  // uio bit positions
  localparam int UIO_COEF_LOAD    = 0;
  localparam int UIO_ADDR_LO      = 1;
  localparam int UIO_ADDR_HI      = 2;
  localparam int UIO_SAMPLE_VALID = 3;
  localparam int UIO_OUT_VALID    = 4;
  localparam int UIO_SAT          = 5;
  localparam logic [7:0] UIO_OE_VAL = 8'hF0;

  typedef logic [ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    CMD_IDLE,
    CMD_COEF,
    CMD_SAMPLE
  } cmd_e;

  typedef struct packed {
    logic [OUT_W-1:0] y;
    logic             sat;
  } out_t;

  // Coefficient write takes priority; the sample on the same edge is dropped.
  function automatic cmd_e decode_cmd(logic coef_load, logic sample_valid);
    if (coef_load)    return CMD_COEF;
    if (sample_valid) return CMD_SAMPLE;
    return CMD_IDLE;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Combinational multiply-accumulate of the delay line against the coefficients.
module fir_mac
  import fir_pkg::*;
(
  input  logic [NUM_TAPS-1:0][DATA_W-1:0] x,
  input  logic [NUM_TAPS-1:0][COEF_W-1:0] c,
  output acc_t                            acc
);

  // NOTE: blocking assignments are correct here: the running sum is a
  // combinational chain evaluated in order, not state.
  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      acc = acc + ACC_W'(x[i]) * ACC_W'(c[i]);
    end
  end

endmodule

// File: rtl/tt_um_fir.sv
// 4-tap unsigned FIR, registered output. Define FIR_SAT_EN to clip results at 255
// and report clipping on the sat flag; otherwise the output wraps.
// rst_n is active-high despite its name.
module tt_um_fir
  import fir_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [NUM_TAPS-1:0][DATA_W-1:0] x_q;
  logic [NUM_TAPS-1:0][COEF_W-1:0] c_q;
  logic                            pending_q;
  logic                            valid_q;
  logic                            sat_q;
  logic [OUT_W-1:0]                y_q;

  cmd_e                  cmd;
  logic [TAP_ADDR_W-1:0] tap_addr;
  acc_t                  acc;
  out_t                  res;
  logic                  unused_uio;

  assign cmd        = decode_cmd(uio_in[UIO_COEF_LOAD], uio_in[UIO_SAMPLE_VALID]);
  assign tap_addr   = uio_in[UIO_ADDR_HI:UIO_ADDR_LO];
  assign unused_uio = &{1'b0, uio_in[7:4]};

  fir_mac u_mac (
    .x   (x_q),
    .c   (c_q),
    .acc (acc)
  );

  function automatic out_t scale(acc_t a);
    out_t r;
`ifdef FIR_SAT_EN
    r.sat = (a >> OUT_SHIFT) > acc_t'(OUT_MAX);
    r.y   = r.sat ? OUT_W'(OUT_MAX) : OUT_W'(a >> OUT_SHIFT);
`else
    r.sat = 1'b0;
    r.y   = OUT_W'(a >> OUT_SHIFT);
`endif
    return r;
  endfunction

  assign res = scale(acc);

  // pending_q marks that the delay line holds a freshly accepted sample whose
  // result is registered on the next enabled edge.
  // NOTE: the coefficient bank is reset like any other register because its
  // reset contents (a moving average) are part of the behaviour, not don't-care.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      x_q       <= '0;
      c_q       <= {NUM_TAPS{COEF_RESET}};
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      y_q       <= '0;
    end else if (ena) begin
      case (cmd)
        CMD_COEF:   c_q[tap_addr] <= ui_in;
        CMD_SAMPLE: x_q <= {x_q[NUM_TAPS-2:0], ui_in};
        default:    ;
      endcase
      pending_q <= (cmd == CMD_SAMPLE);
      valid_q   <= pending_q;
      if (pending_q) begin
        y_q   <= res.y;
        sat_q <= res.sat;
      end
    end else begin
      valid_q <= 1'b0;
    end
  end

  always_comb begin
    uio_out                = '0;
    uio_out[UIO_OUT_VALID] = valid_q & ena;
    uio_out[UIO_SAT]       = sat_q;
  end

  assign uo_out = y_q;
  assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_fir.sv
// Self-checking bench for tt_um_fir: directed scenarios then random traffic
// against a sample-history reference model.
module tb_tt_um_fir;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_fir dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: most recent sample first, coefficients, and results
  // awaiting their output edge.
  int hist[$];
  int coef[4];
  int res_y[$];
  int res_s[$];
  int want_out, want_sat, want_valid;

  task automatic check(input string tag, input int obs, input int want);
    n_checks++;
    assert (obs === want) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    hist = '{0, 0, 0, 0};
    for (int i = 0; i < 4; i++) coef[i] = 64;
    res_y.delete();
    res_s.delete();
    want_out   = 0;
    want_sat   = 0;
    want_valid = 0;
  endtask

  task automatic model_accept(input int sample);
    int sum, sh;
    hist.push_front(sample);
    void'(hist.pop_back());
    sum = 0;
    for (int i = 0; i < 4; i++) sum += coef[i] * hist[i];
    sh = sum / 256;
`ifdef FIR_SAT_EN
    res_y.push_back(sh > 255 ? 255 : sh);
    res_s.push_back(sh > 255 ? 1 : 0);
`else
    res_y.push_back(sh % 256);
    res_s.push_back(0);
`endif
  endtask

  task automatic model_edge(input logic e, input int ui, input logic cl,
                            input int addr, input logic sv);
    if (!e) begin
      want_valid = 0;
      return;
    end
    if (res_y.size() > 0) begin
      want_out   = res_y.pop_front();
      want_sat   = res_s.pop_front();
      want_valid = 1;
    end else begin
      want_valid = 0;
    end
    if (cl)      coef[addr] = ui;
    else if (sv) model_accept(ui);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".uo_out"}, int'(uo_out), want_out);
    check({tag, ".uio_out"}, int'(uio_out),
          (want_sat << 5) | ((want_valid != 0 && ena) ? 16 : 0));
    check({tag, ".uio_oe"}, int'(uio_oe), 'hF0);
  endtask

  task automatic cycle(input string tag, input logic e, input logic [7:0] ui,
                       input logic cl, input logic [1:0] addr, input logic sv);
    @(negedge clk);
    ena    = e;
    ui_in  = ui;
    uio_in = {4'($urandom), sv, addr, cl};
    @(posedge clk);
    if (!rst_n) model_edge(e, int'(ui), cl, int'(addr), sv);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int prev;
    rst_n  = 1'b1;
    ena    = 1'b0;
    ui_in  = '0;
    uio_in = '0;
    model_reset();
    #1;
    check_outputs("reset");
    for (int i = 0; i < 3; i++) cycle("reset_hold", 1'b1, 8'h55, 1'b0, 2'd0, 1'b1);

    @(negedge clk);
    rst_n = 1'b0;
    ena   = 1'b0;

    // Default moving average
    cycle("ma", 1'b1, 8'd100, 1'b0, 2'd0, 1'b1);
    check("ma_first_no_valid", int'(uio_out[4]), 0);
    cycle("ma", 1'b1, 8'd100, 1'b0, 2'd0, 1'b1);
    check("ma_25", int'(uo_out), 25);
    check("ma_25_valid", int'(uio_out[4]), 1);
    cycle("ma", 1'b1, 8'd100, 1'b0, 2'd0, 1'b1);
    check("ma_50", int'(uo_out), 50);
    cycle("ma", 1'b1, 8'd100, 1'b0, 2'd0, 1'b1);
    check("ma_75", int'(uo_out), 75);
    cycle("ma", 1'b1, 8'd0, 1'b0, 2'd0, 1'b0);
    check("ma_100", int'(uo_out), 100);
    cycle("ma_idle", 1'b1, 8'd0, 1'b0, 2'd0, 1'b0);
    check("ma_pulse_once", int'(uio_out[4]), 0);

    // Impulse response
    cycle("imp_load", 1'b1, 8'd128, 1'b1, 2'd0, 1'b0);
    cycle("imp_load", 1'b1, 8'd64,  1'b1, 2'd1, 1'b0);
    cycle("imp_load", 1'b1, 8'd32,  1'b1, 2'd2, 1'b0);
    cycle("imp_load", 1'b1, 8'd16,  1'b1, 2'd3, 1'b0);
    for (int i = 0; i < 4; i++) cycle("imp_flush", 1'b1, 8'd0, 1'b0, 2'd0, 1'b1);
    cycle("imp", 1'b1, 8'd255, 1'b0, 2'd0, 1'b1);
    cycle("imp", 1'b1, 8'd0, 1'b0, 2'd0, 1'b1);
    check("imp_127", int'(uo_out), 127);
    cycle("imp", 1'b1, 8'd0, 1'b0, 2'd0, 1'b1);
    check("imp_63", int'(uo_out), 63);
    cycle("imp", 1'b1, 8'd0, 1'b0, 2'd0, 1'b1);
    check("imp_31", int'(uo_out), 31);
    cycle("imp", 1'b1, 8'd0, 1'b0, 2'd0, 1'b0);
    check("imp_15", int'(uo_out), 15);

    // Saturation / wrap
    for (int a = 0; a < 4; a++) cycle("sat_load", 1'b1, 8'd255, 1'b1, 2'(a), 1'b0);
    for (int i = 0; i < 4; i++) cycle("sat_flush", 1'b1, 8'd0, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) cycle("sat", 1'b1, 8'd255, 1'b0, 2'd0, 1'b1);
    cycle("sat", 1'b1, 8'd0, 1'b0, 2'd0, 1'b0);
`ifdef FIR_SAT_EN
    check("sat_fourth", int'(uo_out), 255);
    check("sat_flag", int'(uio_out[5]), 1);
`else
    check("sat_fourth", int'(uo_out), 248);
    check("sat_flag", int'(uio_out[5]), 0);
`endif

    // Priority: coefficient write wins over a simultaneous sample
    prev = int'(uo_out);
    cycle("prio", 1'b1, 8'd9, 1'b1, 2'd2, 1'b1);
    check("prio_hold", int'(uo_out), prev);
    check("prio_no_valid", int'(uio_out[4]), 0);
    cycle("prio_idle", 1'b1, 8'd0, 1'b0, 2'd0, 1'b0);
    check("prio_no_late_valid", int'(uio_out[4]), 0);
    cycle("prio_next", 1'b1, 8'd0, 1'b0, 2'd0, 1'b1);
    cycle("prio_next", 1'b1, 8'd0, 1'b0, 2'd0, 1'b0);

    // Enable low: sample ignored, nothing changes
    prev = int'(uo_out);
    cycle("ena_off", 1'b0, 8'd77, 1'b0, 2'd0, 1'b1);
    check("ena_off_hold", int'(uo_out), prev);
    cycle("ena_back", 1'b1, 8'd0, 1'b0, 2'd0, 1'b0);
    check("ena_no_valid", int'(uio_out[4]), 0);

    // Asynchronous reset mid-stream
    cycle("stream", 1'b1, 8'd200, 1'b0, 2'd0, 1'b1);
    cycle("stream", 1'b1, 8'd200, 1'b0, 2'd0, 1'b1);
    #3;
    rst_n = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b0;
    ena   = 1'b0;
    cycle("post_rst", 1'b1, 8'd100, 1'b0, 2'd0, 1'b1);
    cycle("post_rst", 1'b1, 8'd0, 1'b0, 2'd0, 1'b0);
    check("post_rst_25", int'(uo_out), 25);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(0, 9) != 0), 8'($urandom),
            ($urandom_range(0, 5) == 0), 2'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
